// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled walk-left/right, bounce and binary count.
// Ports: clk, rst_n, mode, div_val, run, step -> dout (LED bus), tick (update strobe).
module led_pattern_gen #(
  parameter int WIDTH = 10,
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic             run,
  input  logic             step,
  output logic [WIDTH-1:0] dout,
  output logic             tick
);

  localparam logic [WIDTH-1:0] SEED_L = WIDTH'(1);
  localparam logic [WIDTH-1:0] SEED_R = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             init_q, init_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             tick_q;
  logic             adv;

  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] shl, shr;
  logic             is_cnt, dead;
  logic             walk_l, walk_r, bnc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= 2'd0;
      dir_q  <= 1'b0;
      init_q <= 1'b0;
      dout_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      init_q <= init_d;
      dout_q <= dout_d;
      tick_q <= adv;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    adv   = 1'b0;
    if (run) begin
      if (cnt_q == '0) begin
        adv   = 1'b1;
        cnt_d = div_val;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      adv = step;
    end
  end

  always_comb begin
    seed = SEED_L;
    unique case (mode)
      2'd1:    seed = SEED_R;
      2'd3:    seed = '0;
      default: seed = SEED_L;
    endcase
  end

  assign shl    = {dout_q[WIDTH-2:0], 1'b0};
  assign shr    = {1'b0, dout_q[WIDTH-1:1]};
  assign is_cnt = (mode_q == 2'd3);
  // An empty bus in a walking mode can only come from an upset;
  // reseed rather than stay dark forever.
  assign dead   = !is_cnt && (dout_q == '0);
  assign walk_l = !is_cnt && !dead && (mode_q == 2'd0);
  assign walk_r = !is_cnt && !dead && (mode_q == 2'd1);
  assign bnc    = !is_cnt && !dead && (mode_q == 2'd2);

  always_comb begin
    dout_d = dout_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    init_d = init_q;
    if (adv) begin
      if (!init_q || (mode != mode_q)) begin
        dout_d = seed;
        mode_d = mode;
        init_d = 1'b1;
        dir_d  = 1'b0;
      end else begin
        unique case (1'b1)
          is_cnt: dout_d = dout_q + SEED_L;
          dead: begin
            dout_d = seed;
            dir_d  = 1'b0;
          end
          walk_l: dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
          walk_r: dout_d = {dout_q[0], dout_q[WIDTH-1:1]};
          bnc: begin
            if (!dir_q) begin
              dout_d = shl;
              if (shl[WIDTH-1]) dir_d = 1'b1;
            end else begin
              dout_d = shr;
              if (shr == SEED_L) dir_d = 1'b0;
            end
          end
          default: dout_d = dout_q;
        endcase
      end
    end
  end

  always_comb begin
    dout = dout_q;
    tick = tick_q;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (WIDTH=4) against a positional model.
// Directed test-plan steps followed by a randomized phase.
module tb_led_pattern_gen;

  localparam int W  = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [1:0]    mode;
  logic [DW-1:0] div_val;
  logic          run;
  logic          step;
  logic [W-1:0]  dout;
  logic          tick;

  int errors = 0;
  int checks = 0;

  int           m_cnt;
  bit           m_init;
  int           m_mode;
  int           m_pos;
  logic [W-1:0] m_dout;
  logic         m_tick;

  logic [W-1:0] got[$];

  led_pattern_gen #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .div_val(div_val),
    .run(run), .step(step), .dout(dout), .tick(tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pattern(int md, int pos);
    int p;
    int idx;
    case (md)
      0: return W'(1 << (pos % W));
      1: return W'((1 << (W - 1)) >> (pos % W));
      2: begin
        p   = pos % (2 * (W - 1));
        idx = (p < W) ? p : 2 * (W - 1) - p;
        return W'(1 << idx);
      end
      default: return W'(pos % (1 << W));
    endcase
  endfunction

  function automatic void model_reset();
    m_cnt  = 0;
    m_init = 0;
    m_mode = 0;
    m_pos  = 0;
    m_dout = '0;
    m_tick = 1'b0;
  endfunction

  function automatic void model_step();
    bit adv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    adv = 0;
    if (run) begin
      if (m_cnt == 0) begin
        adv   = 1;
        m_cnt = int'(div_val);
      end else begin
        m_cnt--;
      end
    end else begin
      adv = step;
    end
    m_tick = adv;
    if (adv) begin
      if (!m_init || int'(mode) != m_mode) begin
        m_init = 1;
        m_mode = int'(mode);
        m_pos  = 0;
      end else begin
        m_pos++;
      end
      m_dout = pattern(m_mode, m_pos);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("dout", 32'(dout), 32'(m_dout));
    chk("tick", 32'(tick), 32'(m_tick));
  endtask

  task automatic collect(int n);
    int budget;
    budget = 2000;
    got.delete();
    while (got.size() < n && budget > 0) begin
      cyc();
      budget--;
      if (tick) got.push_back(dout);
    end
    chk("collect_count", got.size(), n);
  endtask

  task automatic expect_seq(string tag, logic [W-1:0] exp[]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk(tag, 32'(got[i]), 32'(exp[i]));
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_dout", 32'(dout), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
  endtask

  initial begin
    logic [W-1:0] exp[];
    int g;
    rst_n   = 1'b0;
    mode    = 2'd0;
    div_val = 8'd2;
    run     = 1'b0;
    step    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);

    rst_n = 1'b1;
    run   = 1'b1;
    cyc();
    chk("first_adv_dout", 32'(dout), 32'd1);
    chk("first_adv_tick", 32'(tick), 32'd1);
    g = 0;
    do begin
      cyc();
      g++;
    end while (!tick && g < 20);
    chk("tick_period", g, 3);
    collect(4);
    exp = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    expect_seq("walk_left", exp);

    mode = 2'd1;
    collect(5);
    exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    expect_seq("walk_right", exp);

    mode = 2'd2;
    collect(8);
    exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0100, 4'b0010, 4'b0001, 4'b0010};
    expect_seq("bounce", exp);

    mode    = 2'd3;
    div_val = 8'd0;
    collect(17);
    for (int i = 0; i < 17; i++) begin
      if (i < got.size()) chk("binary", 32'(got[i]), 32'(i % 16));
    end
    repeat (3) begin
      cyc();
      chk("tick_const", 32'(tick), 32'd1);
    end

    mode    = 2'd0;
    div_val = 8'd2;
    collect(2);
    chk("pause_start", 32'(dout), 32'b0010);
    run = 1'b0;
    repeat (20) begin
      cyc();
      chk("pause_hold", 32'(dout), 32'b0010);
      chk("pause_tick", 32'(tick), 32'd0);
    end
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("step_dout", 32'(dout), 32'b0100);
    chk("step_tick", 32'(tick), 32'd1);
    cyc();
    chk("step_single", 32'(tick), 32'd0);
    run  = 1'b1;
    step = 1'b1;
    repeat (8) cyc();
    step = 1'b0;

    mode    = 2'd2;
    div_val = 8'd1;
    collect(5);
    chk("bnc_0100", 32'(got[4]), 32'b0100);
    mode = 2'd3;
    collect(2);
    exp = '{4'b0000, 4'b0001};
    expect_seq("switch_cnt", exp);
    mode = 2'd2;
    collect(2);
    exp = '{4'b0001, 4'b0010};
    expect_seq("switch_back", exp);

    repeat (2) cyc();
    pulse_reset();
    div_val = 8'd5;
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    collect(1);
    chk("rst_seed", 32'(got[0]), 32'b0001);
    g = 0;
    do begin
      cyc();
      g++;
    end while (!tick && g < 50);
    chk("rst_gap", g, 6);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) div_val = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) run = ~run;
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset();
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
